// File: rtl/multdiv_issue.sv
// -----------------------------------------------------------------------------
// multdiv_issue
//
// Issue-and-stall controller that sits between the execute stage and the
// iterative multdiv unit. When a multiply or divide reaches execute, it latches
// the operands and destination register. It fires a one-cycle start pulse into
// multdiv and holds the front end stalled until multdiv reports ready. It then
// hands the captured result to writeback for exactly one cycle. A pipeline
// flush abandons the in-flight operation. A unit that never answers is
// retired with an exception after TIMEOUT cycles of waiting.
//
// Parameters
//   TIMEOUT       maximum cycles spent waiting for md_ready (2..255)
//
// Ports
//   clock         system clock, rising-edge active
//   reset         asynchronous active-high reset
//   ex_is_mult    execute-stage instruction is a multiply
//   ex_is_div     execute-stage instruction is a divide
//   ex_opA/ex_opB execute-stage operands (B is the divisor)
//   ex_rd         execute-stage destination register
//   flush         kill whatever operation is in flight
//   md_result     multdiv result
//   md_exception  multdiv exception flag
//   md_ready      multdiv result-ready flag
//   md_opA/md_opB registered operands, stable from START through DONE
//   md_ctrl_mult  one-cycle multiply start pulse
//   md_ctrl_div   one-cycle divide start pulse
//   stall         freeze front end and execute stage (combinational)
//   busy          controller is not idle
//   wb_valid      one-cycle writeback strobe
//   wb_result     captured result
//   wb_exception  captured exception or timeout
//   wb_rd         captured destination register
// -----------------------------------------------------------------------------
module multdiv_issue #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_is_mult,
  input  logic        ex_is_div,
  input  logic [31:0] ex_opA,
  input  logic [31:0] ex_opB,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [31:0] wb_result,
  output logic        wb_exception,
  output logic [4:0]  wb_rd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The counter is 8 bits wide because TIMEOUT is limited to 255.
  localparam logic [7:0] TIMEOUT_COUNT = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  wait_count;
  logic [7:0]  wait_count_next;
  logic [4:0]  rd_pending;
  logic        issue;

  // A new operation is accepted only from IDLE and only when it is not being
  // flushed in the same cycle.
  assign issue           = (ex_is_mult | ex_is_div) & ~flush;
  assign wait_count_next = wait_count + 8'd1;

  // The front end is frozen from the moment the op is seen in IDLE until the
  // DONE cycle. DONE releases the stall so that the pipeline advances on the
  // same edge that retires the result.
  assign stall = ((state == S_IDLE) & issue) | (state == S_START) | (state == S_WAIT);
  assign busy  = (state != S_IDLE);

  // Main controller. The start pulses and the writeback strobe default low
  // every cycle, so each of them is high for at most one cycle. Operands stay
  // untouched outside IDLE, which keeps them stable for multdiv while busy.
  // Writeback data is only rewritten on a capture, so it keeps its last
  // value between operations.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_count   <= 8'd0;
      rd_pending   <= 5'd0;
      md_opA       <= 32'd0;
      md_opB       <= 32'd0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_result    <= 32'd0;
      wb_exception <= 1'b0;
      wb_rd        <= 5'd0;
    end else begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_valid     <= 1'b0;

      case (state)
        S_IDLE: begin
          // A late md_ready from a flushed op lands here and is ignored.
          if (issue) begin
            md_opA       <= ex_opA;
            md_opB       <= ex_opB;
            rd_pending   <= ex_rd;
            // Multiply takes priority when both op flags are raised.
            md_ctrl_mult <= ex_is_mult;
            md_ctrl_div  <= ~ex_is_mult;
            state        <= S_START;
          end
        end

        S_START: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            wait_count <= 8'd0;
            state      <= S_WAIT;
          end
        end

        S_WAIT: begin
          // Flush beats a simultaneous md_ready, and md_ready beats a
          // timeout that would expire in the same cycle.
          if (flush) begin
            state <= S_IDLE;
          end else if (md_ready) begin
            wb_result    <= md_result;
            wb_exception <= md_exception;
            wb_rd        <= rd_pending;
            wb_valid     <= 1'b1;
            state        <= S_DONE;
          end else if (wait_count_next == TIMEOUT_COUNT) begin
            wb_result    <= 32'd0;
            wb_exception <= 1'b1;
            wb_rd        <= rd_pending;
            wb_valid     <= 1'b1;
            state        <= S_DONE;
          end else begin
            wait_count <= wait_count_next;
          end
        end

        S_DONE: begin
          // The instruction still in execute is the one just retired, so
          // the op flags are deliberately not looked at here.
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_issue.sv
// -----------------------------------------------------------------------------
// tb_multdiv_issue
//
// Scoreboard bench for multdiv_issue. A behavioural multdiv stub answers each
// start pulse after a chosen latency. Every issued operation pushes its
// expected writeback into a queue. An independent monitor pops that queue on
// each wb_valid. It also watches the pulse width and operand stability.
// -----------------------------------------------------------------------------
module tb_multdiv_issue;

  localparam int TO = 8;

  logic        clock;
  logic        reset;
  logic        ex_is_mult;
  logic        ex_is_div;
  logic [31:0] ex_opA;
  logic [31:0] ex_opB;
  logic [4:0]  ex_rd;
  logic        flush;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic        wb_exception;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  // Expected writeback entries, packed as {rd, exception, result}.
  logic [37:0] exp_q[$];

  // Stub configuration, set by the stimulus before each operation.
  int stub_lat    = 1;
  bit stub_enable = 1'b1;
  int stub_count  = 0;
  logic [32:0] stub_resp;

  multdiv_issue #(.TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .ex_is_mult   (ex_is_mult),
    .ex_is_div    (ex_is_div),
    .ex_opA       (ex_opA),
    .ex_opB       (ex_opB),
    .ex_rd        (ex_rd),
    .flush        (flush),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .md_opA       (md_opA),
    .md_opB       (md_opB),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .stall        (stall),
    .busy         (busy),
    .wb_valid     (wb_valid),
    .wb_result    (wb_result),
    .wb_exception (wb_exception),
    .wb_rd        (wb_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference arithmetic of the multdiv unit, returned as {exception, result}.
  // Division truncates toward zero. Divide-by-zero yields all ones with an
  // exception, and the single overflowing quotient is flagged too.
  function automatic logic [32:0] md_model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int q;
    logic [31:0] p;
    sa = int'(a);
    sb = int'(b);
    if (!is_div) begin
      p = a * b;
      return {1'b0, p};
    end
    if (sb == 0) return {1'b1, 32'hFFFF_FFFF};
    if (sa == 32'sh8000_0000 && sb == -1) return {1'b1, a};
    q = sa / sb;
    return {1'b0, 32'(q)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural multdiv: it samples a start pulse and answers stub_lat cycles
  // into WAIT, computing from the operands that the controller presents.
  always @(negedge clock) begin
    md_ready = 1'b0;
    if (reset) begin
      stub_count = 0;
    end else begin
      if (stub_count > 0) begin
        stub_count--;
        if (stub_count == 0) begin
          md_ready     = 1'b1;
          md_result    = stub_resp[31:0];
          md_exception = stub_resp[32];
        end
      end
      if ((md_ctrl_mult || md_ctrl_div) && stub_enable) begin
        stub_count = stub_lat;
        stub_resp  = md_model(md_ctrl_div, md_opA, md_opB);
      end
    end
  end

  // Monitor: it scores writebacks and watches the protocol properties.
  logic        prev_valid = 1'b0;
  logic        prev_pulse = 1'b0;
  logic        prev_busy  = 1'b0;
  logic [31:0] prev_opA   = 32'd0;
  logic [31:0] prev_opB   = 32'd0;

  always @(negedge clock) begin
    logic [37:0] e;
    if (reset) begin
      prev_valid = 1'b0;
      prev_pulse = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (wb_valid) begin
        check("wb_valid_one_cycle", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wb_valid: got wb_valid=1 result 0x%08h expected no writeback", wb_result);
        end else begin
          e = exp_q.pop_front();
          check("wb_result", wb_result, e[31:0]);
          check("wb_exception", 32'(wb_exception), 32'(e[32]));
          check("wb_rd", 32'(wb_rd), 32'(e[37:33]));
        end
      end
      if (md_ctrl_mult || md_ctrl_div) begin
        check("start_pulse_one_cycle", 32'(prev_pulse), 32'd0);
        check("start_pulse_onehot", 32'(md_ctrl_mult & md_ctrl_div), 32'd0);
      end
      if (busy && prev_busy) begin
        check("md_opA_held", md_opA, prev_opA);
        check("md_opB_held", md_opB, prev_opB);
      end
      prev_valid = wb_valid;
      prev_pulse = md_ctrl_mult | md_ctrl_div;
      prev_busy  = busy;
      prev_opA   = md_opA;
      prev_opB   = md_opB;
    end
  end

  // This task issues one operation and pushes its expected writeback. It
  // then follows the stall until the DONE cycle releases it. The op flags
  // are left asserted through DONE, so the controller must not reissue.
  task automatic apply_stimulus(input bit is_div, input bit both, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd,
                                input int lat, input bit no_resp);
    logic [32:0] r;
    int stall_cycles;
    bit done;
    @(negedge clock);
    stub_lat    = lat;
    stub_enable = !no_resp;
    ex_is_mult  = !is_div;
    ex_is_div   = is_div | both;
    ex_opA      = a;
    ex_opB      = b;
    ex_rd       = rd;
    r = no_resp ? {1'b1, 32'd0} : md_model(is_div, a, b);
    exp_q.push_back({rd, r});
    #1;
    check("stall_on_issue", 32'(stall), 32'd1);
    stall_cycles = 1;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      if (c == 0) begin
        check("start_ctrl_mult", 32'(md_ctrl_mult), 32'(!is_div));
        check("start_ctrl_div", 32'(md_ctrl_div), 32'(is_div));
        check("start_md_opA", md_opA, a);
        check("start_md_opB", md_opB, b);
        check("start_busy", 32'(busy), 32'd1);
        ex_opA = $urandom;
        ex_opB = $urandom;
      end
      if (stall) stall_cycles++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL stall_release: got stall still high after 40 cycles expected release");
    end
    check("stall_cycles", 32'(stall_cycles), 32'((no_resp ? TO : lat) + 2));
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clock);
    ex_is_mult = 1'b0;
    ex_is_div  = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_md_opA"}, md_opA, 32'd0);
    check({tag, "_md_opB"}, md_opB, 32'd0);
    check({tag, "_ctrl"}, 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    check({tag, "_wb_result"}, wb_result, 32'd0);
    check({tag, "_wb_exception"}, 32'(wb_exception), 32'd0);
    check({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    bit d;
    bit both;
    int lat;
    reset        = 1'b1;
    ex_is_mult   = 1'b0;
    ex_is_div    = 1'b0;
    ex_opA       = 32'd0;
    ex_opB       = 32'd0;
    ex_rd        = 5'd0;
    flush        = 1'b0;
    md_result    = 32'd0;
    md_exception = 1'b0;
    md_ready     = 1'b0;
    #1;
    check_all_zero("por");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Directed operations taken from the intended use cases.
    apply_stimulus(1'b0, 1'b0, 32'd7, 32'd3, 5'd5, 3, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'd2, -32'sd5, 5'd6, 2, 1'b0);
    apply_stimulus(1'b1, 1'b0, -32'sd20, 32'd3, 5'd7, 4, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'd9, 32'd0, 5'd8, 1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'd123, 32'd456, 5'd9, 1, 1'b1);
    idle_cycles(2);

    // A flush in the third WAIT cycle of a divide. The stub still answers
    // later, while the controller is idle.
    @(negedge clock);
    stub_lat    = 6;
    stub_enable = 1'b1;
    ex_is_div   = 1'b1;
    ex_opA      = 32'd50;
    ex_opB      = 32'd5;
    ex_rd       = 5'd10;
    repeat (4) @(negedge clock);
    flush     = 1'b1;
    ex_is_div = 1'b0;
    #1;
    check("flush_stall_in_wait", 32'(stall), 32'd1);
    @(negedge clock);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_ctrl", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
    repeat (8) @(negedge clock);
    apply_stimulus(1'b0, 1'b0, 32'd4, 32'd5, 5'd12, 2, 1'b0);
    idle_cycles(1);

    // Assert reset asynchronously in the middle of WAIT.
    @(negedge clock);
    stub_lat  = 6;
    ex_is_div = 1'b1;
    ex_opA    = 32'd100;
    ex_opB    = 32'd7;
    ex_rd     = 5'd11;
    repeat (3) @(negedge clock);
    #2;
    ex_is_div = 1'b0;
    reset     = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Back-to-back issue with a single-cycle multdiv latency.
    apply_stimulus(1'b0, 1'b0, 32'd6, 32'd6, 5'd13, 1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'd36, 32'd6, 5'd14, 1, 1'b0);

    // Randomized operations, including simultaneous op flags, divide by
    // zero and a response in the last WAIT cycle before the timeout.
    for (int i = 0; i < 30; i++) begin
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) a = $urandom;
      else a = 32'(int'($urandom_range(0, 200)) - 100);
      if ($urandom_range(0, 1) == 1) b = $urandom;
      else b = 32'(int'($urandom_range(0, 40)) - 20);
      if (d && $urandom_range(0, 5) == 0) b = 32'd0;
      both = !d && ($urandom_range(0, 3) == 0);
      lat  = int'($urandom_range(1, TO));
      apply_stimulus(d, both, a, b, 5'($urandom), lat, 1'b0);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
